// File: rtl/next_audio_pkg.sv
// Shared types and constants for the monitor-side audio elastic buffer.
package next_audio_pkg;
  localparam int SAMPLE_W = 32;
  localparam int UCOUNT_W = 8;
  localparam logic [SAMPLE_W-1:0] SILENCE = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN
  } audio_state_e;
endpackage

// File: rtl/next_audio_fifo_mem.sv
// DEPTH x 32 sample storage: synchronous write, registered read.
module next_audio_fifo_mem
  import next_audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);
  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/next_audio_fifo.sv
// Elastic sample buffer feeding the I2S serializer, with 22 kHz repeat,
// underrun fill, end-of-stream drain and host pacing indications.
module next_audio_fifo
  import next_audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int PRIME_LEVEL = 4,
  parameter int HIGH_WATER  = 12
) (
  input  logic                mon_clk,
  input  logic                hw_reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                audio_start,
  input  logic                audio_end,
  input  logic                audio_22khz,
  input  logic                sample_take,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                request_mode,
  output logic                request_underrun,
  output logic                request_tick,
  output logic [AW:0]         level,
  output logic                overflow,
  output logic [UCOUNT_W-1:0] underrun_count
);
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME_LEVEL);
  localparam logic [AW:0] HIGH_LVL  = (AW+1)'(HIGH_WATER);

  audio_state_e        state_reg;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]         level_reg;
  logic                rep_reg, overflow_reg, tick_reg;
  logic                byp_valid_reg;
  logic [SAMPLE_W-1:0] byp_data_reg, sample_out_reg, mem_data, head;
  logic [UCOUNT_W-1:0] ucount_reg;
  logic active, take_ev, rep_take, pop, empty_take, full, push, flush;

  always_comb begin
    active     = (state_reg == ST_PRIME) || (state_reg == ST_RUN);
    take_ev    = sample_take && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
    rep_take   = take_ev && audio_22khz && !rep_reg;
    pop        = take_ev && !rep_take && (level_reg != '0);
    empty_take = take_ev && !rep_take && (level_reg == '0);
    full       = (level_reg == FULL_LVL);
    push       = sample_valid && active && (!full || pop);
    flush      = (state_reg == ST_DRAIN) && audio_start && !audio_end;
    rd_ptr_next = (!hw_reset_n || flush) ? '0 : rd_ptr_reg + AW'(pop);
    // The RAM prefetches the next head; a write landing on that slot is
    // not yet visible in the read register, so it is forwarded for a cycle.
    head = byp_valid_reg ? byp_data_reg : mem_data;
  end

  next_audio_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (mon_clk),
    .wr_en   (push && hw_reset_n),
    .wr_addr (wr_ptr_reg),
    .wr_data (sample_in),
    .rd_addr (rd_ptr_next),
    .rd_data (mem_data)
  );

  always_ff @(posedge mon_clk) begin
    if (!hw_reset_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      rep_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      tick_reg       <= 1'b0;
      byp_valid_reg  <= 1'b0;
      byp_data_reg   <= SILENCE;
      sample_out_reg <= SILENCE;
      ucount_reg     <= '0;
    end else begin
      tick_reg      <= 1'b0;
      rd_ptr_reg    <= rd_ptr_next;
      byp_valid_reg <= push && (wr_ptr_reg == rd_ptr_next);
      byp_data_reg  <= sample_in;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
      if (sample_valid && active && full && !pop) overflow_reg <= 1'b1;
      if (rep_take) rep_reg <= 1'b1;
      if (pop) begin
        sample_out_reg <= head;
        rep_reg        <= 1'b0;
        // Threshold uses the occupancy right after this pop, ignoring a concurrent write.
        tick_reg       <= (state_reg == ST_RUN) && ((level_reg - 1'b1) < HIGH_LVL);
      end
      if (empty_take) begin
        sample_out_reg <= SILENCE;
        rep_reg        <= 1'b0;
        if (state_reg == ST_RUN) begin
          tick_reg <= 1'b1;
          if (ucount_reg != '1) ucount_reg <= ucount_reg + 1'b1;
        end
      end
      case (state_reg)
        ST_IDLE: if (audio_start) begin
          state_reg    <= ST_PRIME;
          overflow_reg <= 1'b0;
          rep_reg      <= 1'b0;
        end
        ST_PRIME: begin
          if (audio_end) state_reg <= ST_DRAIN;
          else if (level_reg >= PRIME_LVL) state_reg <= ST_RUN;
        end
        ST_RUN: if (audio_end) state_reg <= ST_DRAIN;
        ST_DRAIN: begin
          if (flush) begin
            state_reg      <= ST_PRIME;
            wr_ptr_reg     <= '0;
            level_reg      <= '0;
            rep_reg        <= 1'b0;
            sample_out_reg <= SILENCE;
          end else if (empty_take) begin
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sample_out       = sample_out_reg;
  assign request_mode     = active;
  assign request_underrun = (state_reg == ST_RUN) && (level_reg == '0);
  assign request_tick     = tick_reg;
  assign level            = level_reg;
  assign overflow         = overflow_reg;
  assign underrun_count   = ucount_reg;
endmodule

// File: tb/tb_next_audio_fifo.sv
// Scoreboard bench for next_audio_fifo: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_next_audio_fifo;
  localparam int DEPTH = 16;
  localparam int HW    = 12;
  localparam int PL    = 4;

  logic        clk = 1'b0;
  logic        rst_n, vld, st, en, k22, tk;
  logic [31:0] din;
  logic [31:0] sample_out;
  logic        request_mode, request_underrun, request_tick, overflow;
  logic [4:0]  level;
  logic [7:0]  underrun_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  next_audio_fifo #(.DEPTH(DEPTH), .AW(4), .PRIME_LEVEL(PL), .HIGH_WATER(HW)) dut (
    .mon_clk          (clk),
    .hw_reset_n       (rst_n),
    .sample_in        (din),
    .sample_valid     (vld),
    .audio_start      (st),
    .audio_end        (en),
    .audio_22khz      (k22),
    .sample_take      (tk),
    .sample_out       (sample_out),
    .request_mode     (request_mode),
    .request_underrun (request_underrun),
    .request_tick     (request_tick),
    .level            (level),
    .overflow         (overflow),
    .underrun_count   (underrun_count)
  );

  typedef struct {
    logic [31:0] so;
    logic        tick;
    int          lvl;
    logic        ovf;
    logic        mode;
    logic        urun;
    int          uc;
  } exp_t;
  exp_t sb[$];

  // Reference model: 0 idle, 1 prime, 2 run, 3 drain
  logic [31:0] m_q[$];
  int          m_st = 0;
  logic        m_rep = 0, m_ovf = 0, m_tick = 0;
  int          m_uc = 0;
  logic [31:0] m_so = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int lvl0;
    bit popped, to_idle;
    if (!rst_n) begin
      m_q.delete(); m_st = 0; m_rep = 0; m_ovf = 0; m_uc = 0; m_so = 0; m_tick = 0;
    end else begin
      lvl0 = m_q.size(); popped = 0; to_idle = 0; m_tick = 0;
      if ((m_st == 2 || m_st == 3) && tk) begin
        if (k22 && !m_rep) m_rep = 1;
        else if (lvl0 > 0) begin
          m_so = m_q.pop_front(); m_rep = 0; popped = 1;
          if (m_st == 2 && m_q.size() < HW) m_tick = 1;
        end else begin
          m_so = 0; m_rep = 0;
          if (m_st == 2) begin m_tick = 1; if (m_uc < 255) m_uc++; end
          else to_idle = 1;
        end
      end
      if ((m_st == 1 || m_st == 2) && vld) begin
        if (lvl0 < DEPTH || popped) m_q.push_back(din);
        else m_ovf = 1;
      end
      case (m_st)
        0: if (st) begin m_st = 1; m_ovf = 0; m_rep = 0; end
        1: if (en) m_st = 3; else if (lvl0 >= PL) m_st = 2;
        2: if (en) m_st = 3;
        default: begin
          if (st && !en) begin m_q.delete(); m_rep = 0; m_so = 0; m_st = 1; end
          else if (to_idle) begin m_st = 0; m_so = 0; end
        end
      endcase
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic s,
                      input logic e, input logic t);
    exp_t x;
    vld = v; din = d; st = s; en = e; tk = t;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    x.so = m_so; x.tick = m_tick; x.lvl = m_q.size(); x.ovf = m_ovf;
    x.mode = (m_st == 1 || m_st == 2); x.urun = (m_st == 2 && m_q.size() == 0); x.uc = m_uc;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [31:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle(); step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); endtask
  task automatic take(); step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); endtask
  task automatic start(); step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("sb_sample_out", sample_out, e.so);
      cmp("sb_request_tick", 32'(request_tick), 32'(e.tick));
      cmp("sb_level", 32'(level), e.lvl);
      cmp("sb_overflow", 32'(overflow), 32'(e.ovf));
      cmp("sb_request_mode", 32'(request_mode), 32'(e.mode));
      cmp("sb_request_underrun", 32'(request_underrun), 32'(e.urun));
      cmp("sb_underrun_count", 32'(underrun_count), e.uc);
    end
  end

  initial begin
    rst_n = 0; vld = 0; st = 0; en = 0; k22 = 0; tk = 0; din = 0;
    @(posedge clk); #1;
    idle(); idle();
    rst_n = 1;
    cmp("reset_level", 32'(level), 0);
    cmp("reset_sample_out", sample_out, 0);
    cmp("reset_mode", 32'(request_mode), 0);

    // Prime with four samples, enter RUN, first take
    start();
    for (int i = 1; i <= 4; i++) wr(32'h00010001 * i);
    idle();
    take();
    cmp("first_take_sample", sample_out, 32'h00010001);
    cmp("first_take_tick", 32'(request_tick), 1);
    cmp("first_take_level", 32'(level), 3);

    // Overflow at full, then write concurrent with take at full
    rst_n = 0; idle(); rst_n = 1;
    start();
    for (int i = 0; i < 17; i++) wr(32'h10000000 + i);
    cmp("full_level", 32'(level), 16);
    cmp("full_overflow", 32'(overflow), 1);
    step(1'b1, 32'h20000000, 1'b0, 1'b0, 1'b1);
    cmp("full_wr_take_level", 32'(level), 16);
    cmp("full_wr_take_sample", sample_out, 32'h10000000);
    cmp("full_wr_take_tick", 32'(request_tick), 0);

    // 22 kHz repeat
    rst_n = 0; idle(); rst_n = 1;
    start();
    wr(32'hAAAA5555); wr(32'hBBBB6666); wr(32'hCCCC7777); wr(32'hDDDD8888);
    idle();
    k22 = 1;
    take();
    take(); cmp("rep_a1", sample_out, 32'hAAAA5555);
    take(); cmp("rep_a2", sample_out, 32'hAAAA5555);
    take(); cmp("rep_b1", sample_out, 32'hBBBB6666);
    take(); cmp("rep_b2", sample_out, 32'hBBBB6666);
    cmp("rep_level", 32'(level), 2);

    // Underrun from level 1
    k22 = 0;
    take();
    take(); cmp("ur_head", sample_out, 32'hDDDD8888); cmp("ur_tick0", 32'(request_tick), 1);
    take(); cmp("ur_zero1", sample_out, 0); cmp("ur_tick1", 32'(request_tick), 1);
    take(); cmp("ur_zero2", sample_out, 0); cmp("ur_tick2", 32'(request_tick), 1);
    cmp("ur_flag", 32'(request_underrun), 1);
    cmp("ur_count", 32'(underrun_count), 2);

    // End-of-stream drain
    wr(32'h0000000A); wr(32'h0000000B); wr(32'h0000000C);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    wr(32'h0000DEAD);
    cmp("drain_wr_ignored", 32'(level), 3);
    take(); take(); take();
    cmp("drain_last", sample_out, 32'h0000000C);
    take();
    cmp("drain_mode", 32'(request_mode), 0);
    cmp("drain_sample_zero", sample_out, 0);
    cmp("drain_ucount", 32'(underrun_count), 2);

    // Reset mid-RUN, then start+end together from RUN
    start();
    for (int i = 0; i < 8; i++) wr(32'h30000000 + i);
    idle();
    rst_n = 0; idle(); rst_n = 1;
    cmp("midrst_level", 32'(level), 0);
    cmp("midrst_mode", 32'(request_mode), 0);
    cmp("midrst_ucount", 32'(underrun_count), 0);
    start();
    for (int i = 0; i < 4; i++) wr(32'h40000000 + i);
    idle();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cmp("start_end_mode", 32'(request_mode), 0);
    cmp("start_end_level", 32'(level), 4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 99) == 0) k22 = ~k22;
      step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) < 2, $urandom_range(0, 99) < 35);
    end
    rst_n = 1;
    idle(); idle();
    @(negedge clk); @(negedge clk);
    cmp("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/next_audio_fifo.md
Name: next_audio_fifo

Overview:
- Elastic buffer between the packet decode path and the I2S serializer, on the mon_clk side of the sound box.
- Accepts 32-bit stereo samples ({L[15:0], R[15:0]}) as the host delivers them, and hands one sample per I2S frame to the serializer.
- Produces the request mode, request tick and underrun indications that the monitor-link sender uses to pace the host.
- Implements 22 kHz sample repeat, underrun fill and end-of-stream drain.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥4.
- AW, 4: log2(DEPTH).
- PRIME_LEVEL, 4: level required to leave PRIME; 1..DEPTH.
- HIGH_WATER, 12: request_tick is issued only while the level after a pop is < HIGH_WATER.

Ports:
- mon_clk in 1: sole clock; all logic on posedge.
- hw_reset_n in 1: synchronous, active-low reset.
- sample_in in 32: decoded audio sample.
- sample_valid in 1: 1-cycle write strobe.
- audio_start in 1: stream start pulse.
- audio_end in 1: end-of-stream pulse.
- audio_22khz in 1: level; when 1, each sample is played twice.
- sample_take in 1: 1-cycle pulse from the serializer, once per LRCK frame.
- sample_out out 32: sample the serializer currently plays.
- request_mode out 1: stream active (PRIME or RUN).
- request_underrun out 1: RUN with level==0.
- request_tick out 1: 1-cycle "send one more sample" pulse.
- level out AW+1: current occupancy, 0..DEPTH.
- overflow out 1: sticky; a write was dropped while full.
- underrun_count out 8: saturating count of underrun takes.

Behaviour:
- Reset is synchronous on hw_reset_n==0:
  - state=IDLE; pointers, level and rep flag = 0.
  - sample_out, overflow, underrun_count, request_tick = 0.
  - Reset mid-stream discards all contents with no drain.
- States: IDLE, PRIME, RUN, DRAIN.
  - IDLE -> PRIME on audio_start.
  - PRIME -> RUN when level ≥ PRIME_LEVEL, evaluated on the registered level.
  - PRIME or RUN -> DRAIN on audio_end.
  - DRAIN -> IDLE when level==0 and the current sample's repeat is complete.
  - DRAIN + audio_start: flush pointers, clear rep, go to PRIME.
  - audio_start in PRIME or RUN is ignored.
  - audio_end and audio_start in the same cycle: audio_end wins.
  - audio_end in IDLE is ignored.
- Writes:
  - Accepted only in PRIME and RUN; writes in IDLE or DRAIN are discarded silently.
  - A write when level==DEPTH is dropped and sets overflow, which is cleared only by reset or by audio_start from IDLE.
- Take (RUN or DRAIN, on sample_take):
  - If audio_22khz==1 and rep==0: sample_out is unchanged and rep is set; no pop.
  - Otherwise, if level>0: pop the head and register it into sample_out the next cycle (latency 1); rep is cleared.
  - Otherwise, when empty: sample_out becomes 0, request_underrun stays high, and underrun_count increments and saturates at 255. In DRAIN, an empty take is not counted.
  - sample_take in IDLE or PRIME: sample_out holds 0; no pop.
- Simultaneous write and pop: level unchanged; a write to the full FIFO in the same cycle as a pop is accepted.
- request_tick:
  - Pulses in the cycle after each pop in RUN when (level after pop) < HIGH_WATER.
  - Pulses in the cycle after each empty take in RUN.
  - Never pulses in PRIME, DRAIN or IDLE.
  - PRIME is paced by the sender's mode flag, not by ticks.
- Pointers are AW bits and wrap modulo DEPTH. Level is an explicit counter of AW+1 bits, never derived from pointer difference.
- Entering IDLE forces sample_out to 0 in the same transition cycle.

Decomposition:
- Shared package (next_audio_pkg):
  - State enum.
  - Sample width constant 32.
  - Silence value 32'h0.
  - Underrun counter width 8.
- One sub-module, next_audio_fifo_mem:
  - Synchronous-write, registered-read DEPTH×32 storage with wr_en/wr_addr/rd_addr.
  - The parent owns pointers, level and all control.

Test Plan:
- Reset, audio_start, then 4 writes (0x00010001..0x00040004) → RUN entered the cycle after level==4; first take → sample_out=0x00010001 one cycle later; request_tick pulses (level 3 < 12).
- 16 writes in PRIME then a 17th → level=16, overflow=1, 17th sample never emerges; a write concurrent with a take at full is accepted and level stays 16.
- audio_22khz=1 with samples A, B queued, four takes → sample_out sequence A, A, B, B; only 2 pops, so level drops by 2.
- RUN with level 1, three takes → sample_out=head, then 0, 0; request_underrun=1; underrun_count=2; request_tick pulses on all three takes.
- audio_end with 3 queued → writes ignored; 3 takes play the queued samples; the 4th take gives state=IDLE, sample_out=0, request_mode=0, underrun_count unchanged.
- hw_reset_n low for 1 cycle mid-RUN with level 8 → next cycle level=0, IDLE, all outputs 0; audio_start and audio_end in the same cycle from RUN → DRAIN.
